// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - serial pattern transmitter, MSB of the active window first
// Optional build macro SEQ_GEN_REPEAT_EN adds the repeat_en input for gapless looping.
module sequence_generator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] length,
    input  logic             advance,
`ifdef SEQ_GEN_REPEAT_EN
    input  logic             repeat_en,
`endif
    output logic             w_out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] bit_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] len_clamped;
    logic             reload;

    // Zero and oversize lengths both mean "send the full pattern".
    assign len_clamped = ((length == '0) || (length > WIDTH_C)) ? WIDTH_C : length;

`ifdef SEQ_GEN_REPEAT_EN
    assign reload = repeat_en;
`else
    assign reload = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (advance && (idx_q == '0) && !reload) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            shreg   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg <= pattern;
                        len_q <= len_clamped;
                    end
                end
                LOAD: idx_q <= len_q - ONE;
                SHIFT: begin
                    // idx 0 either reloads for another pass or stays put; it never wraps.
                    if (advance) begin
                        if (idx_q != '0)
                            idx_q <= idx_q - ONE;
                        else if (reload)
                            idx_q <= len_q - ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign shifted = shreg >> idx_q;
    assign w_out   = (state_q == SHIFT) ? shifted[0] : 1'b0;
    assign valid   = (state_q == SHIFT);
    assign busy    = (state_q == LOAD) || (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign state   = state_q;
    assign bit_idx = idx_q;

endmodule
